// File: rtl/disp_bcd_conv.sv
// Purpose: memory-mapped display register; a CPU write to DISP_ADDR is converted
//          from 16-bit unsigned binary into four packed BCD digits by double-dabble.
// Latency/backpressure: 16 cycles per conversion. There is no backpressure. One write
//          arriving during a conversion is buffered, and the last such write wins.
// Ports:
//   clk, rst       - system clock (rising edge), async active-high reset
//   writeM         - CPU data-memory write strobe
//   addressM       - CPU data-memory address (15 bits)
//   outM           - CPU write data (16-bit unsigned)
//   bcd            - {thousands, hundreds, tens, ones} of the last completed conversion
//   overflow       - last completed value exceeded 9999
//   busy           - a conversion is in progress
//   valid          - at least one conversion has completed since reset
module disp_bcd_conv #(
  parameter logic [14:0] DISP_ADDR = 15'h6001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeM,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  output logic [15:0] bcd,
  output logic        overflow,
  output logic        busy,
  output logic        valid
);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state_q;
  logic [15:0] src_q;
  logic [19:0] acc_q;
  logic [4:0]  cnt_q;
  logic        pend_q;
  logic [15:0] pend_val_q;
  logic [15:0] bcd_q;
  logic        ovf_q;
  logic        busy_q;
  logic        valid_q;

  logic        hit;
  logic [19:0] acc_adj;
  logic [35:0] dd_shift;
  logic [19:0] acc_d;
  logic [15:0] src_d;
  logic        last_iter;

  assign hit       = writeM && (addressM == DISP_ADDR);
  assign last_iter = (cnt_q == 5'd15);

  // Add-3 correction on every nibble that is 5 or more, applied before the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < 5; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) begin
        acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end
    end
  end

  // Shift {accumulator, source} left as a single 36-bit word. The accumulator MSB
  // falls off the top, which is harmless because 65535 needs only 19 bits of BCD.
  assign dd_shift = {acc_adj, src_q} << 1;
  assign acc_d    = dd_shift[35:16];
  assign src_d    = dd_shift[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            src_q   <= outM;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          acc_q <= acc_d;
          src_q <= src_d;
          cnt_q <= cnt_q + 5'd1;
          if (last_iter) begin
            bcd_q   <= acc_d[15:0];
            ovf_q   <= |acc_d[19:16];
            valid_q <= 1'b1;
            cnt_q   <= '0;
            if (hit || pend_q) begin
              // A write on the completion edge itself is newer than any pending value.
              src_q  <= hit ? outM : pend_val_q;
              acc_q  <= '0;
              pend_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (hit) begin
            pend_q     <= 1'b1;
            pend_val_q <= outM;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign valid    = valid_q;

endmodule

// File: doc/disp_bcd_conv.md
DISP_BCD_CONV -- requirements
Module: disp_bcd_conv

Interface
REQ-001 Parameter DISP_ADDR, default 15'h6001, the Hack data-memory address decoded as the display register.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port writeM  input  1  CPU data-memory write strobe.
REQ-005 Port addressM  input  15  CPU data-memory address.
REQ-006 Port outM  input  16  CPU write data, unsigned.
REQ-007 Port bcd  output  16  four packed BCD digits {thousands, hundreds, tens, ones}, feeding the 7-segment multiplexer.
REQ-008 Port overflow  output  1  high when the last converted value exceeds 9999.
REQ-009 Port busy  output  1  high while a conversion is in progress.
REQ-010 Port valid  output  1  high once at least one conversion has completed since reset.

Function
REQ-011 Write hit: writeM=1 and addressM==DISP_ADDR, sampled on rising clk.
REQ-012 FSM states: IDLE, CONV; busy SHALL equal (state==CONV), registered.
REQ-013 IDLE, hit: capture outM into a 16-bit shift source, clear a 20-bit BCD accumulator and a 5-bit iteration counter, go to CONV.
REQ-014 CONV: exactly one double-dabble iteration per cycle; add 3 to each of the five accumulator nibbles whose value is >=5, then shift {accumulator, source} left by one.
REQ-015 CONV ends after 16 iterations; on the 16th iteration edge, bcd <= accumulator[15:0], overflow <= (accumulator[19:16]!=0), valid <= 1, state <= IDLE.
REQ-016 Latency: hit sampled at edge N; busy high from N through N+15; bcd/overflow/valid update at edge N+16.
REQ-017 bcd and overflow SHALL hold the last completed result throughout any conversion.
REQ-018 Hit during CONV: store outM in a 16-bit pending register, set pending flag; a later hit overwrites the pending register (last write wins).
REQ-019 At CONV completion with pending flag set: skip IDLE, load the pending value, clear the flag, restart CONV on the same edge; busy stays high continuously.
REQ-020 Hit on the exact completion edge: counts as pending per REQ-018 and starts per REQ-019.
REQ-021 writeM=1 with any other address, or writeM=0, SHALL have no effect.
REQ-022 Full 16-bit unsigned range; 65535 SHALL yield accumulator 20'h65535.

Reset
REQ-023 rst high SHALL immediately force state IDLE, bcd=16'h0000, overflow=0, busy=0, valid=0, pending flag=0, counter=0.
REQ-024 rst asserted mid-conversion SHALL abandon it; no partial result is ever committed to bcd.
REQ-025 First hit after rst release SHALL start a conversion normally.

Verification
REQ-026 Write 1234 to DISP_ADDR -> busy high 16 cycles; at edge N+16, bcd=16'h1234, overflow=0, valid=1.
REQ-027 Write 65535 -> bcd=16'h5535, overflow=1; then write 0 -> bcd=16'h0000, overflow=0.
REQ-028 Write 9999, then 42 at cycle N+3, then 7 at N+5 -> edge N+16 bcd=16'h9999; busy unbroken; edge N+32 bcd=16'h0007; 42 never shown.
REQ-029 Write 500 to DISP_ADDR+1, and writeM=0 with DISP_ADDR -> busy stays 0, bcd unchanged.
REQ-030 Write 8888, assert rst at N+7 -> outputs all zero immediately; after release, write 10 -> bcd=16'h0010 at 16 cycles.
